// File: rtl/uart_tx_serializer_if.sv
// Parallel-side and serial-side signals of the UART transmit serializer.
// The slave modport is the serializer; the master modport is the FIFO read side and pad.
interface uart_tx_serializer_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_en;
  logic                  par_typ;
  logic [5:0]            prescale;
  logic                  tx_out;
  logic                  busy;

  modport master (
    output p_data,
    output data_valid,
    output par_en,
    output par_typ,
    output prescale,
    input  tx_out,
    input  busy
  );

  modport slave (
    input  p_data,
    input  data_valid,
    input  par_en,
    input  par_typ,
    input  prescale,
    output tx_out,
    output busy
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: frames a parallel word as start, LSB-first data, optional
// parity and stop bits, each held for a latched prescale of 8, 16 or 32 clocks.
module uart_tx_serializer #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input logic                CLK,
  input logic                RST,
  uart_tx_serializer_if.slave bus
);

  localparam int unsigned IdxW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e                r_state;
  logic [5:0]            r_edge_cnt;
  logic [IdxW-1:0]       r_bit_idx;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic [5:0]            r_prescale;
  logic                  r_tx;
  logic                  r_busy;

  logic                  w_legal;
  logic                  w_last_edge;
  logic                  w_parity;
  logic [DATA_WIDTH-1:0] w_shift_next;

  assign w_legal      = (bus.prescale == 6'd8) || (bus.prescale == 6'd16) ||
                        (bus.prescale == 6'd32);
  assign w_last_edge  = (r_edge_cnt == (r_prescale - 6'd1));
  // Parity comes from the latched word; the shift copy is already consumed by then.
  assign w_parity     = (^r_data) ^ r_par_typ;
  assign w_shift_next = r_shift >> 1;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= StIdle;
      r_edge_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_prescale <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      if (r_state != StIdle) begin
        r_edge_cnt <= w_last_edge ? 6'd0 : r_edge_cnt + 6'd1;
      end
      unique case (r_state)
        StIdle: begin
          if (bus.data_valid && w_legal) begin
            r_shift    <= bus.p_data;
            r_data     <= bus.p_data;
            r_par_en   <= bus.par_en;
            r_par_typ  <= bus.par_typ;
            r_prescale <= bus.prescale;
            r_edge_cnt <= '0;
            r_bit_idx  <= '0;
            r_state    <= StStart;
            r_tx       <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        StStart: begin
          if (w_last_edge) begin
            r_state <= StData;
            r_tx    <= r_shift[0];
          end
        end
        StData: begin
          if (w_last_edge) begin
            if (r_bit_idx == LastIdx) begin
              if (r_par_en) begin
                r_state <= StParity;
                r_tx    <= w_parity;
              end else begin
                r_state <= StStop;
                r_tx    <= 1'b1;
              end
            end else begin
              r_shift   <= w_shift_next;
              r_tx      <= w_shift_next[0];
              r_bit_idx <= r_bit_idx + IdxW'(1);
            end
          end
        end
        StParity: begin
          if (w_last_edge) begin
            r_state <= StStop;
            r_tx    <= 1'b1;
          end
        end
        StStop: begin
          if (w_last_edge) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= StIdle;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx_out = r_tx;
  assign bus.busy   = r_busy;

endmodule
